// File: rtl/mem_sram_controller_pkg.sv
// mem_sram_controller_pkg: shared FSM state type and default SRAM base address
package mem_sram_controller_pkg;
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   localparam int SRAM_BASE_DEFAULT = 1024;
endpackage

// File: rtl/mem_sram_controller.sv
// mem_sram_controller: splits 32-bit pipeline loads/stores into two held 16-bit SRAM half-accesses
// Ports: clk/rst (sync, active-high); rd_en/wr_en/address/write_data from EXE/MEM;
// read_data and sram_freeze back to the pipeline; sram_addr/sram_dq_out/sram_dq_oe/sram_we_n
// drive the SRAM, sram_dq_in returns SRAM read data.
module mem_sram_controller
   import mem_sram_controller_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int SRAM_BASE = SRAM_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        sram_freeze,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);
   state_t      state, state_n;
   logic [3:0]  cnt;
   logic [31:0] addr_q, wdata_q;
   logic [16:0] word;
   logic        op_wr, req, active, last, drive;
   always_comb begin
      req         = rd_en | wr_en;
      active      = state == LOW || state == HIGH;
      last        = active && cnt == 4'(HOLD_CYCLES - 1);
      drive       = active && op_wr;
      word        = 17'((addr_q - 32'(SRAM_BASE)) >> 2);
      state_n     = state == IDLE ? (req ? LOW : IDLE) :
                    state == DONE ? IDLE :
                    last ? (state == LOW ? HIGH : DONE) : state;
      sram_addr   = active ? {word, state == HIGH} : '0;
      sram_dq_out = drive ? (state == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : '0;
      sram_dq_oe  = drive;
      sram_we_n   = !drive;
      // Combinational so the requesting instruction stalls in its very first cycle.
      sram_freeze = req && state != DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         read_data <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         op_wr     <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (active && !last) ? cnt + 4'd1 : '0;
         if (state == IDLE && req) begin
            addr_q  <= address;
            wdata_q <= write_data;
            op_wr   <= wr_en;
         end
         // Sample each half on the final hold cycle, when the SRAM output has settled longest.
         if (last && !op_wr && state == LOW) read_data[15:0] <= sram_dq_in;
         if (last && !op_wr && state == HIGH) read_data[31:16] <= sram_dq_in;
      end
   end
endmodule

// File: tb/tb_mem_sram_controller.sv
// tb_mem_sram_controller: directed self-checking bench for mem_sram_controller
module tb_mem_sram_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        sram_freeze;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic [15:0] mem [16];
   int checks = 0;
   int errors = 0;

   mem_sram_controller #(.HOLD_CYCLES(2), .SRAM_BASE(1024)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .sram_freeze(sram_freeze),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] = sram_dq_out;

   assign sram_dq_in = mem[sram_addr[3:0]];

   task automatic test_reset;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (sram_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got %0b want 0", sram_freeze); end
      checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %0b want 1", sram_we_n); end
      checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %0b want 0", sram_dq_oe); end
      checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", sram_addr); end
      checks++; if (sram_dq_out !== 16'd0) begin errors++; $display("FAIL reset_dq_out got %0h want 0", sram_dq_out); end
      checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got %0h want 0", read_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++; if (sram_freeze !== 1'b0) begin errors++; $display("FAIL idle_freeze c%0d got %0b want 0", c, sram_freeze); end
         checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL idle_we_n c%0d got %0b want 1", c, sram_we_n); end
         checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL idle_oe c%0d got %0b want 0", c, sram_dq_oe); end
         checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL idle_addr c%0d got %0h want 0", c, sram_addr); end
         @(negedge clk);
      end
   endtask

   task automatic test_write;
      logic        ef [6] = '{1, 1, 1, 1, 1, 0};
      logic [17:0] ea [6] = '{0, 2, 2, 3, 3, 0};
      logic [15:0] ed [6] = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
      logic        ew [6] = '{1, 0, 0, 0, 0, 1};
      wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (sram_freeze !== ef[c]) begin errors++; $display("FAIL wr_freeze c%0d got %0b want %0b", c, sram_freeze, ef[c]); end
         checks++; if (sram_addr !== ea[c]) begin errors++; $display("FAIL wr_addr c%0d got %0h want %0h", c, sram_addr, ea[c]); end
         checks++; if (sram_dq_out !== ed[c]) begin errors++; $display("FAIL wr_dq c%0d got %0h want %0h", c, sram_dq_out, ed[c]); end
         checks++; if (sram_we_n !== ew[c]) begin errors++; $display("FAIL wr_we_n c%0d got %0b want %0b", c, sram_we_n, ew[c]); end
         checks++; if (sram_dq_oe !== !ew[c]) begin errors++; $display("FAIL wr_oe c%0d got %0b want %0b", c, sram_dq_oe, !ew[c]); end
         if (c == 5) wr_en = 1'b0;
         @(negedge clk);
      end
      checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL wr_keeps_read_data got %0h want 0", read_data); end
      checks++; if ({mem[3], mem[2]} !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %0h want deadbeef", {mem[3], mem[2]}); end
   endtask

   task automatic test_read;
      logic [17:0] ea [6] = '{0, 2, 2, 3, 3, 0};
      logic        ef [6] = '{1, 1, 1, 1, 1, 0};
      mem[2] = 16'hBEEF; mem[3] = 16'hDEAD;
      rd_en = 1'b1; address = 32'd1028; write_data = 32'h0;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (sram_freeze !== ef[c]) begin errors++; $display("FAIL rd_freeze c%0d got %0b want %0b", c, sram_freeze, ef[c]); end
         checks++; if (sram_addr !== ea[c]) begin errors++; $display("FAIL rd_addr c%0d got %0h want %0h", c, sram_addr, ea[c]); end
         checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rd_bus c%0d got we_n %0b oe %0b want 1 0", c, sram_we_n, sram_dq_oe); end
         if (c == 3) begin
            checks++; if (read_data !== 32'h0000BEEF) begin errors++; $display("FAIL rd_low_half got %0h want 0000beef", read_data); end
         end
         if (c == 5) begin
            checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0h want deadbeef", read_data); end
            rd_en = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      logic [17:0] ea [12] = '{0, 4, 4, 5, 5, 0, 0, 0, 0, 1, 1, 0};
      logic        ef [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
      mem[0] = 16'h1111; mem[1] = 16'h2222;
      wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++; if (sram_addr !== ea[c]) begin errors++; $display("FAIL b2b_addr c%0d got %0h want %0h", c, sram_addr, ea[c]); end
         checks++; if (sram_freeze !== ef[c]) begin errors++; $display("FAIL b2b_freeze c%0d got %0b want %0b", c, sram_freeze, ef[c]); end
         if (c == 5) begin wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; end
         if (c == 11) begin
            checks++; if (read_data !== 32'h22221111) begin errors++; $display("FAIL b2b_read_data got %0h want 22221111", read_data); end
            rd_en = 1'b0;
         end
         @(negedge clk);
      end
      checks++; if ({mem[5], mem[4]} !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_mem got %0h want cafef00d", {mem[5], mem[4]}); end
   endtask

   task automatic test_both;
      logic ew [6] = '{1, 0, 0, 0, 0, 1};
      rd_en = 1'b1; wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (sram_we_n !== ew[c]) begin errors++; $display("FAIL both_we_n c%0d got %0b want %0b", c, sram_we_n, ew[c]); end
         if (c == 5) begin rd_en = 1'b0; wr_en = 1'b0; end
         @(negedge clk);
      end
      checks++; if (read_data !== 32'h22221111) begin errors++; $display("FAIL both_read_data got %0h want 22221111", read_data); end
      checks++; if ({mem[1], mem[0]} !== 32'h12345678) begin errors++; $display("FAIL both_mem got %0h want 12345678", {mem[1], mem[0]}); end
   endtask

   task automatic test_abandon;
      logic [17:0] ea [6] = '{0, 6, 6, 7, 7, 0};
      logic        ef [6] = '{1, 1, 0, 0, 0, 0};
      wr_en = 1'b1; address = 32'd1036; write_data = 32'hA5A55A5A;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (sram_addr !== ea[c]) begin errors++; $display("FAIL abandon_addr c%0d got %0h want %0h", c, sram_addr, ea[c]); end
         checks++; if (sram_freeze !== ef[c]) begin errors++; $display("FAIL abandon_freeze c%0d got %0b want %0b", c, sram_freeze, ef[c]); end
         if (c == 1) wr_en = 1'b0;
         @(negedge clk);
      end
      checks++; if ({mem[7], mem[6]} !== 32'hA5A55A5A) begin errors++; $display("FAIL abandon_mem got %0h want a5a55a5a", {mem[7], mem[6]}); end
   endtask

   task automatic test_reset_mid;
      mem[2] = 16'h1357; mem[3] = 16'h2468;
      rd_en = 1'b1; address = 32'd1028;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (sram_addr !== 18'd3) begin errors++; $display("FAIL rstmid_in_high got %0h want 3", sram_addr); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rstmid_bus got we_n %0b oe %0b want 1 0", sram_we_n, sram_dq_oe); end
      checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL rstmid_read_data got %0h want 0", read_data); end
      checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL rstmid_addr got %0h want 0", sram_addr); end
      checks++; if (sram_freeze !== 1'b1) begin errors++; $display("FAIL rstmid_freeze got %0b want 1", sram_freeze); end
      rst = 1'b0; rd_en = 1'b0;
      #1;
      checks++; if (sram_freeze !== 1'b0) begin errors++; $display("FAIL rstmid_freeze_idle got %0b want 0", sram_freeze); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (read_data !== 32'd0 || sram_addr !== 18'd0) begin errors++; $display("FAIL rstmid_after got rd %0h addr %0h want 0 0", read_data, sram_addr); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      test_reset;
      test_idle;
      test_write;
      test_read;
      test_back_to_back;
      test_both;
      test_abandon;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
